// File: rtl/temp_file_guys.sv
// AES-128 key schedule: 11 round keys expanded combinationally from the key and registered.
// Optional TEMP_FILE_GUYS_KEY_REG_EN adds a key input register (latency 2 instead of 1).
module temp_file_guys (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    key,
  output logic [1407:0]   expanded_key
);

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = '0;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int unsigned r);
    logic [7:0] c;
    c = '0;
    case (r)
      1:  c = 8'h01;
      2:  c = 8'h02;
      3:  c = 8'h04;
      4:  c = 8'h08;
      5:  c = 8'h10;
      6:  c = 8'h20;
      7:  c = 8'h40;
      8:  c = 8'h80;
      9:  c = 8'h1b;
      10: c = 8'h36;
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [127:0]  key_src;
  logic [1407:0] expanded_key_d;
  logic [1407:0] expanded_key_q;

`ifdef TEMP_FILE_GUYS_KEY_REG_EN
  logic [127:0] key_d;
  logic [127:0] key_q;

  always_comb begin
    key_d = key;
  end

  always_ff @(posedge clk) begin
    if (rst) key_q <= '0;
    else     key_q <= key_d;
  end

  assign key_src = key_q;
`else
  assign key_src = key;
`endif

  // Each round is its own block-local vector so the chain has no self-referencing net.
  for (genvar r = 0; r < 11; r++) begin : g_rk
    logic [127:0] rk;
    if (r == 0) begin : g_init
      assign rk = key_src;
    end else begin : g_next
      logic [31:0] prev_last;
      logic [31:0] temp;
      logic [31:0] w0, w1, w2, w3;
      assign prev_last = g_rk[r-1].rk[31:0];
      assign temp = sub_word({prev_last[23:0], prev_last[31:24]}) ^ {rcon(r), 24'h0};
      assign w0 = g_rk[r-1].rk[127:96] ^ temp;
      assign w1 = g_rk[r-1].rk[95:64]  ^ w0;
      assign w2 = g_rk[r-1].rk[63:32]  ^ w1;
      assign w3 = g_rk[r-1].rk[31:0]   ^ w2;
      assign rk = {w0, w1, w2, w3};
    end
    assign expanded_key_d[1407-128*r -: 128] = rk;
  end

  always_ff @(posedge clk) begin
    if (rst) expanded_key_q <= '0;
    else     expanded_key_q <= expanded_key_d;
  end

  assign expanded_key = expanded_key_q;

endmodule

// File: tb/tb_temp_file_guys.sv
// Bench for temp_file_guys: known FIPS-197 vectors plus random keys against a
// reference schedule whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_temp_file_guys;

`ifdef TEMP_FILE_GUYS_KEY_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B = 128'h5468617473206D79204B756E67204675;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  key;
  logic [1407:0] expanded_key;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]    sbox_m [256];
  logic [1407:0] exp_q [$];

  temp_file_guys dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .expanded_key (expanded_key)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model_expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) begin
      w[i] = k[127:96];
      k = k << 32;
    end
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    res = '0;
    for (int i = 0; i < 44; i++) res = {res[1375:0], w[i]};
    return res;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] v, input int unsigned r);
    return 128'(v >> (128 * (10 - r)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [1407:0] obs, input logic [1407:0] exp);
    for (int unsigned r = 0; r < 11; r++)
      check($sformatf("%s rk%0d", tag, r), rk_of(obs, r), rk_of(exp, r));
  endtask

  initial begin
    build_sbox();

    rst = 1'b1;
    key = {$urandom, $urandom, $urandom, $urandom};
    step();
    step();
    check_all("reset", expanded_key, '0);

    rst = 1'b0;
    key = KEY_A;
    repeat (LAT) step();
    check("fips_rk1",  rk_of(expanded_key, 1),  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("fips_rk10", rk_of(expanded_key, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_all("fips_full", expanded_key, model_expand(KEY_A));

    key = KEY_B;
    repeat (LAT) step();
    check("b_rk0",  rk_of(expanded_key, 0),  KEY_B);
    check("b_rk1",  rk_of(expanded_key, 1),  128'hE232FCF191129188B159E4E6D679A293);
    check("b_rk10", rk_of(expanded_key, 10), 128'h28FDDEF86DA4244ACCC0A4FE3B316F26);

    repeat (3) step();
    check_all("stable", expanded_key, model_expand(KEY_B));

    exp_q.delete();
    for (int c = 0; c < 12; c++) begin
      key = (c % 2 == 0) ? KEY_A : KEY_B;
      exp_q.push_back(model_expand(key));
      step();
      if (exp_q.size() == LAT) check_all($sformatf("alt%0d", c), expanded_key, exp_q.pop_front());
    end

    key = KEY_B;
    step();
    key = KEY_A;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("mid_rst", expanded_key, '0);
    repeat (LAT) step();
    check_all("post_rst", expanded_key, model_expand(KEY_A));

    key = '0;
    repeat (LAT) step();
    check("zero_rk1",  rk_of(expanded_key, 1),  128'h62636363626363636263636362636363);
    check("zero_rk10", rk_of(expanded_key, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    exp_q.delete();
    for (int c = 0; c < 200; c++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(model_expand(key));
      step();
      if (exp_q.size() == LAT) check_all($sformatf("rnd%0d", c), expanded_key, exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/temp_file_guys.md
TEMP_FILE_GUYS -- requirements
Module: temp_file_guys

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port key, input, 128 bits: AES-128 cipher key; key[127:120] is key byte 0.
REQ-005 Port expanded_key, output, 1408 bits: full AES-128 key schedule, i.e. 11 round keys; registered.

Function
REQ-006 The block SHALL compute the FIPS-197 AES-128 key expansion: 44 32-bit words w[0..43].
REQ-007 Word layout: w[i] SHALL sit at expanded_key[1407-32*i -: 32]; round key r is expanded_key[1407-128*r -: 128]; w[0] is the MSB word.
REQ-008 Words w[0..3] SHALL equal key[127:96], key[95:64], key[63:32] and key[31:0].
REQ-009 For i not a multiple of 4, w[i] SHALL be w[i-4] XOR w[i-1].
REQ-010 For i a multiple of 4, w[i] SHALL be w[i-4] XOR SubWord(RotWord(w[i-1])) XOR {Rcon[i/4], 24'h0}.
REQ-011 RotWord SHALL be a left byte rotation {b1,b2,b3,b0}; SubWord SHALL apply the standard AES forward S-box to each byte.
REQ-012 Rcon[1..10] SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
REQ-013 The expansion SHALL be purely combinational from its key source, using 40 S-box lookups (4 per round).
REQ-014 expanded_key SHALL be captured in a register on every rising clk edge while rst is low.
REQ-015 Latency SHALL be 1 cycle from a key change to expanded_key, in the default build.
REQ-016 A new key SHALL be accepted on any cycle, with no handshake; back-to-back key changes each appear after the fixed latency, in order.
REQ-017 A stable key SHALL keep expanded_key constant.

Reset
REQ-018 While rst is high at a clk edge, all internal registers SHALL load zero, so expanded_key becomes 1408'h0.
REQ-019 A reset asserted mid-stream SHALL discard any pending result.
REQ-020 After rst is released, the first valid result SHALL appear after the normal latency.

Configuration
REQ-021 Macro TEMP_FILE_GUYS_KEY_REG_EN: when defined, key SHALL first be captured in a 128-bit input register, which resets to 0.
REQ-022 With the macro defined, the expansion SHALL use the registered key and latency SHALL be 2 cycles.
REQ-023 Without the macro, no input register SHALL exist and latency SHALL be 1 cycle.
REQ-024 Both builds SHALL produce identical steady-state values.

Verification
REQ-025 Reset: hold rst high for 2 cycles with any key -> expanded_key == 0.
REQ-026 Key 000102030405060708090a0b0c0d0e0f, then wait for the latency -> round key 1 = d6aa74fdd2af72fadaa678f1d6ab76fe; round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-027 Key 5468617473206D79204B756E67204675 -> round key 0 = key; round key 1 = E232FCF191129188B159E4E6D679A293; round key 10 = 28FDDEF86DA4244ACCC0A4FE3B316F26.
REQ-028 Alternate the two keys above on consecutive cycles -> outputs alternate the same way, delayed by exactly the latency (1 cycle, or 2 with the macro).
REQ-029 Assert rst for 1 cycle while the key is held -> output 0 on the following cycle, then the correct schedule after the latency.
REQ-030 Key all-zeros -> round key 1 = 62636363626363636263636362636363; round key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
